// File: rtl/cla_pkg.sv
// Shared constants for the multi-cycle carry-lookahead adder.
// Holds FSM state encodings and the lookahead group width.
package cla_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int CLA_GROUP = 4;

endpackage

// File: rtl/cla_seq_adder_if.sv
// Start/busy/done handshake bundle for cla_seq_adder.
// The sub signal exists only when CLA_SUB_EN is defined.
interface cla_seq_adder_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             cin;
`ifdef CLA_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;

`ifdef CLA_SUB_EN
    modport master (
        output start, x, y, cin, sub,
        input  busy, done, s, cout, ovf
    );
    modport slave (
        input  start, x, y, cin, sub,
        output busy, done, s, cout, ovf
    );
`else
    modport master (
        output start, x, y, cin,
        input  busy, done, s, cout, ovf
    );
    modport slave (
        input  start, x, y, cin,
        output busy, done, s, cout, ovf
    );
`endif

endinterface

// File: rtl/cla_group4.sv
// 4-bit carry-lookahead slice with group generate/propagate.
// All internal carries are formed directly from ci, no ripple.
module cla_group4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       g,
    output logic       p,
    output logic       co
);

    logic [3:0] gi;
    logic [3:0] pi;
    logic [3:0] c;

    always_comb begin
        gi   = a & b;
        pi   = a ^ b;
        c[0] = ci;
        c[1] = gi[0] | (pi[0] & ci);
        c[2] = gi[1] | (pi[1] & gi[0])
             | (pi[1] & pi[0] & ci);
        c[3] = gi[2] | (pi[2] & gi[1])
             | (pi[2] & pi[1] & gi[0])
             | (pi[2] & pi[1] & pi[0] & ci);
        g    = gi[3] | (pi[3] & gi[2])
             | (pi[3] & pi[2] & gi[1])
             | (pi[3] & pi[2] & pi[1] & gi[0]);
        p    = &pi;
        co   = g | (p & ci);
        s    = pi ^ c;
    end

endmodule

// File: rtl/cla_seq_adder.sv
// Multi-cycle CLA adder: CHUNK bits per clock, carry held between cycles.
// Define CLA_SUB_EN to add the sub port (x + ~y + 1).
module cla_seq_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    cla_seq_adder_if.slave bus
);

    localparam int N  = WIDTH / CHUNK;
    localparam int NG = CHUNK / CLA_GROUP;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    if ((WIDTH % CHUNK) != 0 || (CHUNK % CLA_GROUP) != 0 || CHUNK < CLA_GROUP) begin : g_bad_cfg
        $error("cla_seq_adder: illegal WIDTH/CHUNK");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [CHUNK-1:0] a_c;
    logic [CHUNK-1:0] b_c;
    logic [CHUNK-1:0] sum_c;
    logic [NG:0]      gci;
    logic [NG-1:0]    gg;
    logic [NG-1:0]    gp;
    logic [NG-1:0]    gco;
    logic             blk_g;
    logic             blk_p;
    logic             chunk_co;
    logic             c_msb;
    logic             sub_sel;

    always_comb begin
        a_c = '0;
        b_c = '0;
        for (int i = 0; i < N; i++) begin
            if (idx_q == IW'(i)) begin
                a_c = opa_q[i*CHUNK +: CHUNK];
                b_c = opb_q[i*CHUNK +: CHUNK];
            end
        end
    end

    assign gci[0] = carry_q;

    for (genvar j = 0; j < NG; j++) begin : g_grp
        cla_group4 u_grp (
            .a  (a_c[j*CLA_GROUP +: CLA_GROUP]),
            .b  (b_c[j*CLA_GROUP +: CLA_GROUP]),
            .ci (gci[j]),
            .s  (sum_c[j*CLA_GROUP +: CLA_GROUP]),
            .g  (gg[j]),
            .p  (gp[j]),
            .co (gco[j])
        );
        assign gci[j+1] = gco[j];
    end

    // Chunk-level G/P lookahead gives the chunk carry-out without the group chain.
    always_comb begin
        blk_g = 1'b0;
        blk_p = 1'b1;
        for (int j = 0; j < NG; j++) begin
            blk_g = gg[j] | (gp[j] & blk_g);
            blk_p = blk_p & gp[j];
        end
        chunk_co = blk_g | (blk_p & carry_q);
        c_msb    = a_c[CHUNK-1] ^ b_c[CHUNK-1] ^ sum_c[CHUNK-1];
    end

`ifdef CLA_SUB_EN
    assign sub_sel = bus.sub;
`else
    assign sub_sel = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        s_d     = s_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (bus.start) begin
                    state_d = ST_RUN;
                    opa_d   = bus.x;
                    opb_d   = sub_sel ? ~bus.y : bus.y;
                    carry_d = sub_sel | bus.cin;
                    idx_d   = '0;
                end
            end
            ST_RUN: begin
                for (int i = 0; i < N; i++) begin
                    if (idx_q == IW'(i)) begin
                        s_d[i*CHUNK +: CHUNK] = sum_c;
                    end
                end
                carry_d = gci[NG];
                idx_d   = idx_q + IW'(1);
                if (idx_q == LAST) begin
                    cout_d  = chunk_co;
                    ovf_d   = c_msb ^ chunk_co;
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            s_q     <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            s_q     <= s_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.s    = s_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_cla_seq_adder.sv
// Bench for cla_seq_adder at WIDTH=16, CHUNK=4 (N=4).
// Directed and random operations checked against an arithmetic model.
module tb_cla_seq_adder;

    localparam int W = 16;
    localparam int C = 4;
    localparam int N = W / C;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    cla_seq_adder_if #(.WIDTH(W)) bus ();

    cla_seq_adder #(.WIDTH(W), .CHUNK(C)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: {ovf, cout, s} from plain modulo arithmetic.
    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic ci, input logic sb);
        logic [15:0] bb;
        logic [16:0] full;
        logic        c0;
        logic        o;
        bb   = sb ? ~b : b;
        c0   = sb ? 1'b1 : ci;
        full = {1'b0, a} + {1'b0, bb} + {16'd0, c0};
        o    = (a[15] == bb[15]) && (full[15] != a[15]);
        return {o, full[16], full[15:0]};
    endfunction

    task automatic drive(input logic [15:0] a, input logic [15:0] b,
                         input logic ci, input logic sb);
        bus.x   = a;
        bus.y   = b;
        bus.cin = ci;
`ifdef CLA_SUB_EN
        bus.sub = sb;
`else
        if (sb) $error("FAIL drive: sub requested without CLA_SUB_EN");
`endif
    endtask

    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic ci, input logic sb);
        int lat;
        int bcnt;
        logic [17:0] e;
        e = model(a, b, ci, sb);
        @(negedge clk);
        bus.start = 1'b1;
        drive(a, b, ci, sb);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat  = 0;
        bcnt = 0;
        while (!bus.done && lat < 20) begin
            if (bus.busy) bcnt++;
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_lat"}, lat, N);
        chk({tag, "_busy"}, bcnt, N);
        chk({tag, "_s"}, {16'd0, bus.s}, {16'd0, e[15:0]});
        chk({tag, "_cout"}, {31'd0, bus.cout}, {31'd0, e[16]});
        chk({tag, "_ovf"}, {31'd0, bus.ovf}, {31'd0, e[17]});
        @(posedge clk);
        #1;
        chk({tag, "_pulse"}, {31'd0, bus.done}, 32'd0);
        chk({tag, "_hold"}, {16'd0, bus.s}, {16'd0, e[15:0]});
    endtask

    initial begin
        int          lat;
        int          dn;
        logic [15:0] cap_s;
        logic [17:0] e;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rc;
        logic        rs;

        n_chk     = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        drive(16'd0, 16'd0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_s", {16'd0, bus.s}, 32'd0);
        chk("rst_cout", {31'd0, bus.cout}, 32'd0);
        chk("rst_ovf", {31'd0, bus.ovf}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("add6_9", 16'h0006, 16'h0009, 1'b0, 1'b0);
        run_op("carry", 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        run_op("ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0);
        run_op("cin", 16'h00FF, 16'h0000, 1'b1, 1'b0);
        run_op("negovf", 16'h8000, 16'h8000, 1'b0, 1'b0);
`ifdef CLA_SUB_EN
        run_op("sub5_7", 16'h0005, 16'h0007, 1'b0, 1'b1);
        run_op("sub7_5", 16'h0007, 16'h0005, 1'b0, 1'b1);
        run_op("sub_cin", 16'h0007, 16'h0005, 1'b1, 1'b1);
`endif

        // start pulsed while busy must be ignored
        e = model(16'h0123, 16'h0456, 1'b0, 1'b0);
        @(negedge clk);
        bus.start = 1'b1;
        drive(16'h0123, 16'h0456, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        drive(16'hAAAA, 16'h5555, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        dn    = 0;
        cap_s = '0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                dn++;
                cap_s = bus.s;
            end
        end
        chk("ign_pulses", dn, 1);
        chk("ign_s", {16'd0, cap_s}, {16'd0, e[15:0]});

        // start held through done: back-to-back accept
        e = model(16'h00AA, 16'h0055, 1'b0, 1'b0);
        @(negedge clk);
        bus.start = 1'b1;
        drive(16'h00AA, 16'h0055, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        lat = 0;
        while (!bus.done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("b2b_lat1", lat, N);
        chk("b2b_s1", {16'd0, bus.s}, {16'd0, e[15:0]});
        drive(16'h1234, 16'h1111, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("b2b_busy", {31'd0, bus.busy}, 32'd1);
        lat = 1;
        while (!bus.done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("b2b_lat2", lat, N + 1);
        chk("b2b_s2", {16'd0, bus.s}, 32'h2345);
        @(posedge clk);
        #1;

        // reset during the second RUN cycle
        @(negedge clk);
        bus.start = 1'b1;
        drive(16'h4321, 16'h1234, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_busy", {31'd0, bus.busy}, 32'd0);
        chk("mid_done", {31'd0, bus.done}, 32'd0);
        chk("mid_s", {16'd0, bus.s}, 32'd0);
        chk("mid_cout", {31'd0, bus.cout}, 32'd0);
        chk("mid_ovf", {31'd0, bus.ovf}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) dn++;
        end
        chk("mid_nodone", dn, 0);
        run_op("post_rst", 16'h4321, 16'h1234, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
`ifdef CLA_SUB_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            run_op("rand", ra, rb, rc, rs);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cla_seq_adder.md
# cla_seq_adder

Parametrised multi-cycle carry-lookahead adder, the successor to the fixed 4-bit combinational CLA. Operands of WIDTH bits are added CHUNK bits per clock through a chain of 4-bit lookahead groups, with the chunk carry held in a register between cycles. A start/busy/done handshake controls the transfer, and the result carries carry-out and signed-overflow flags. It serves as the wide arithmetic unit for lab datapaths that cannot close timing on a full-width combinational CLA.

## Interface
- WIDTH, 32: operand and result width; must be a multiple of CHUNK.
- CHUNK, 8: bits processed per cycle; must be a multiple of 4. N = WIDTH/CHUNK compute cycles.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; one clock domain, asynchronous assert, active-low.
- start  in  1  request; sampled only in IDLE or DONE.
- x  in  WIDTH  operand A; sampled on the accepting edge.
- y  in  WIDTH  operand B; sampled on the accepting edge.
- cin  in  1  carry-in; sampled on the accepting edge.
- sub  in  1  subtract select; present only with CLA_SUB_EN.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse; result valid.
- s  out  WIDTH  sum; registered; held until the next accept.
- cout  out  1  carry out of bit WIDTH-1.
- ovf  out  1  signed overflow: carry into MSB XOR cout.

## Operation
- FSM states:
  - IDLE: on start, go to RUN.
  - RUN: stay for N cycles, then go to DONE.
  - DONE: on start, go to RUN; otherwise go to IDLE.
- Accept, on a start edge in IDLE or DONE:
  - Latch x into opa.
  - Latch y into opb. With CLA_SUB_EN and sub=1, latch ~y instead.
  - Latch cin into the carry register. With CLA_SUB_EN and sub=1, force the carry to 1.
  - Clear idx to 0.
- Each RUN cycle:
  - Chunk idx of opa and opb plus the carry register feeds CHUNK/4 cascaded 4-bit lookahead groups.
  - The group G/P signals form the chunk carry-out.
  - The chunk sum is written into s[idx*CHUNK +: CHUNK].
  - The carry register takes the chunk carry-out, and idx increments.
- Last chunk (idx = N-1):
  - cout takes the chunk carry-out.
  - ovf takes the carry into bit WIDTH-1 XOR the chunk carry-out.
  - The state moves to DONE.
- start while busy is ignored; there is no queueing and no error flag.
- Arithmetic is modulo 2^WIDTH. Subtraction computes x + ~y + 1, and cout=1 means no borrow.
- WIDTH = CHUNK is legal (N=1).

## Timing
- Reset values: state=IDLE, busy=0, done=0, s=0, cout=0, ovf=0, idx=0, carry register=0.
- Latency: start accepted at edge k; done is high during the cycle after edge k+N.
- busy is high during cycles k+1 .. k+N.
- done is high for exactly one cycle. s, cout and ovf are stable from the moment done rises until the next accept.
- Back-to-back: start asserted while done=1 is accepted at that edge. busy rises next cycle; throughput is one result per N+1 cycles.
- Reset asserted mid-RUN: immediate return to all reset values. The partial result is discarded and no done is produced.
- Partial s bits are visible during RUN and are undefined to consumers until done.
- The critical path is one CHUNK-bit lookahead chain plus the carry register; there is no full-width combinational path.

## Configuration
- CLA_SUB_EN defined:
  - The sub port exists.
  - sub=1 latches ~y and forces the carry-in to 1; cin is ignored for that operation.
- CLA_SUB_EN undefined:
  - No sub port; add only.
  - Behaviour is otherwise identical.

## Structure
- Package cla_pkg holds:
  - the FSM state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - the constant CLA_GROUP=4 (lookahead group width).
- Sub-module cla_group4: 4-bit lookahead slice with inputs a[3:0], b[3:0], ci and outputs s[3:0], g, p, co. It is instantiated CHUNK/4 times per chunk.
- Top-level contents: FSM, operand registers, idx counter, carry register, output registers.

## Test plan
All scenarios use WIDTH=16, CHUNK=4, so N=4.
- 0x0006 + 0x0009, cin=0 -> s=0x000F, cout=0, ovf=0; done 4 cycles after the accepting edge, busy high for 4 cycles.
- 0xFFFF + 0x0001, cin=0 -> s=0x0000, cout=1, ovf=0. Then 0x7FFF + 0x0001 -> s=0x8000, cout=0, ovf=1.
- CLA_SUB_EN, sub=1: 0x0005 - 0x0007 -> s=0xFFFE, cout=0. Then 0x0007 - 0x0005 -> s=0x0002, cout=1.
- start pulsed during RUN with different operands -> ignored; the first result is unchanged and exactly one done pulse occurs.
- start held through done, second operands 0x1234 + 0x1111 -> accepted on the done edge, next done at +5 cycles with s=0x2345.
- rst_n low at the 2nd RUN cycle -> all outputs 0 immediately, no done. A fresh start after release gives a correct result.
